id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register with hazard control for the CPU pipeline. Registers decoded operand values, register indices and control fields into the execute stage that feeds the ALU forwarding mux. Detects load-use hazards and inserts a bubble. Freezes on data-memory wait and defers a branch flush that arrives during a wait. Keeps a saturating stall-cycle counter for performance readout.

## Interface
- DATA_W, 32, operand width
- REG_W, 4, register index width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- d_valid  in  1  decode slot holds a real instruction
- d_R2, d_R3, d_DestR  in  REG_W  source and destination indices
- d_R2res, d_R3res  in  DATA_W  register-file read values
- d_ExtndSel  in  2  immediate-extend select
- d_immF  in  1  immediate operand flag
- d_MemRead, d_MemWrite, d_RegWrite  in  1  control bits
- d_AluOp  in  4  ALU operation
- flush  in  1  taken branch resolved in execute; squash decode
- mem_req  in  1  memory stage has an access outstanding
- mem_ready  in  1  data memory completes the access this cycle
- e_valid, e_R2, e_R3, e_DestR, e_R2res, e_R3res, e_ExtndSel, e_immF, e_MemRead, e_MemWrite, e_RegWrite, e_AluOp  out  (widths as d_*)  registered execute-stage fields
- stall_fd  out  1  hold PC and IF/ID register
- stall_xm  out  1  hold EX/MEM and MEM/WB registers
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Source use by decode instruction:
  - R2 is used when ~(d_immF & d_ExtndSel[1]).
  - R3 is used when ~d_immF | (d_ExtndSel == 2'b00).
- lu_hazard = d_valid & e_valid & e_MemRead & e_RegWrite & ((useR2 & d_R2 == e_DestR) | (useR3 & d_R3 == e_DestR)). No R0 exclusion.
- mem_stall = mem_req & ~mem_ready.
- FSM states:
  - RUN: default state.
  - WAIT: entered when mem_stall is high in RUN; stays while mem_stall; returns to RUN on the first cycle with mem_stall low.
- pending_flush register: set when flush is high while mem_stall is high; cleared on the cycle the held update is released.
- flush_eff = flush | pending_flush.
- Execute-register update per edge, priority highest first:
  1. rst: all e_* = 0, state = RUN, pending_flush = 0, stall_cnt = 0.
  2. mem_stall: hold all e_* unchanged.
  3. flush_eff: load a bubble (e_valid = 0, all control bits 0, indices 0, data 0).
  4. lu_hazard: load a bubble.
  5. Otherwise: load d_* fields; e_valid = d_valid.
- Bubble loads force e_MemRead, e_MemWrite and e_RegWrite to 0, so the downstream forwarder never matches on a bubble.
- Stall outputs:
  - stall_fd = mem_stall | (lu_hazard & ~flush_eff). On a flush the front end must be free to take the branch target.
  - stall_xm = mem_stall.
- stall_cnt increments by 1 on every edge where stall_fd is high and saturates at 16'hFFFF.

## Timing
- All e_* outputs are registered, with 1-cycle latency from d_* to e_*. Reset value of every output is 0.
- stall_fd and stall_xm are combinational from the current-cycle inputs and state; they are valid in the same cycle.
- A load-use hazard costs exactly one bubble. On the next cycle e_valid = 0, lu_hazard falls, and the held decode instruction advances.
- Memory wait of N cycles holds e_* for N edges. The first edge with mem_ready high (or mem_req low) performs the normal priority update.
- Flush during a wait is applied on the release edge, whether it arrived in the first, a middle or the last wait cycle.
- Flush together with lu_hazard (no wait): bubble, stall_fd = 0.
- rst asserted mid-wait or mid-stall: next edge returns to reset values and drops pending_flush.

## Test plan
- Reset: hold rst for 2 cycles with d_valid = 1 -> all e_* = 0, stall_fd = 0, stall_cnt = 0.
- Load-use: load to DestR = 5 in execute, decode instruction with d_R3 = 5 and d_immF = 0 -> stall_fd = 1 for one cycle, one bubble (e_valid = 0), then decode fields appear in e_* the next cycle. stall_cnt = 1.
- Immediate masking: same case with d_immF = 1 and d_ExtndSel = 2'b10 using R3 = 5 -> no stall; with d_R2 = 5 and d_ExtndSel = 2'b10 -> no stall.
- Memory wait: mem_req = 1 and mem_ready = 0 for 3 cycles with e_R2res = 32'hDEADBEEF -> e_* unchanged for 3 cycles, stall_xm = 1, stall_cnt = 3, then normal advance.
- Deferred flush: flush pulse in the 2nd cycle of a 4-cycle wait -> e_* held through the wait, bubble loaded on the release edge, pending_flush = 0 afterwards.
- Saturation: force 70000 stall cycles -> stall_cnt = 16'hFFFF and stays there.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle d_* -> e_*, bubbles on load-use or flush, freezes on memory wait.
// A flush seen during a wait is remembered and applied on the release edge.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_W-1:0]  d_R2,
  input  logic [REG_W-1:0]  d_R3,
  input  logic [REG_W-1:0]  d_DestR,
  input  logic [DATA_W-1:0] d_R2res,
  input  logic [DATA_W-1:0] d_R3res,
  input  logic [1:0]        d_ExtndSel,
  input  logic              d_immF,
  input  logic              d_MemRead,
  input  logic              d_MemWrite,
  input  logic              d_RegWrite,
  input  logic [3:0]        d_AluOp,
  input  logic              flush,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              e_valid,
  output logic [REG_W-1:0]  e_R2,
  output logic [REG_W-1:0]  e_R3,
  output logic [REG_W-1:0]  e_DestR,
  output logic [DATA_W-1:0] e_R2res,
  output logic [DATA_W-1:0] e_R3res,
  output logic [1:0]        e_ExtndSel,
  output logic              e_immF,
  output logic              e_MemRead,
  output logic              e_MemWrite,
  output logic              e_RegWrite,
  output logic [3:0]        e_AluOp,
  output logic              stall_fd,
  output logic              stall_xm,
  output logic [15:0]       stall_cnt
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       pending_flush;
  logic       use_r2;
  logic       use_r3;
  logic       lu_hazard;
  logic       mem_stall;
  logic       flush_eff;

  always_comb begin
    use_r2    = ~(d_immF & d_ExtndSel[1]);
    use_r3    = ~d_immF | (d_ExtndSel == 2'b00);
    mem_stall = mem_req & ~mem_ready;
    flush_eff = flush | pending_flush;
    lu_hazard = d_valid & e_valid & e_MemRead & e_RegWrite &
                ((use_r2 & (d_R2 == e_DestR)) | (use_r3 & (d_R3 == e_DestR)));
    // During a flush the front end must be free to fetch the branch target.
    stall_fd  = mem_stall | (lu_hazard & ~flush_eff);
    stall_xm  = mem_stall;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_stall) state_nxt = WAIT;
      WAIT:    if (!mem_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      stall_cnt     <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (mem_stall) begin
        if (flush) pending_flush <= 1'b1;
      end else if (state == WAIT) begin
        pending_flush <= 1'b0;
      end
      if (stall_fd && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (!mem_stall && (flush_eff || lu_hazard))) begin
      e_valid    <= 1'b0;
      e_R2       <= '0;
      e_R3       <= '0;
      e_DestR    <= '0;
      e_R2res    <= '0;
      e_R3res    <= '0;
      e_ExtndSel <= 2'b00;
      e_immF     <= 1'b0;
      e_MemRead  <= 1'b0;
      e_MemWrite <= 1'b0;
      e_RegWrite <= 1'b0;
      e_AluOp    <= 4'h0;
    end else if (!mem_stall) begin
      e_valid    <= d_valid;
      e_R2       <= d_R2;
      e_R3       <= d_R3;
      e_DestR    <= d_DestR;
      e_R2res    <= d_R2res;
      e_R3res    <= d_R3res;
      e_ExtndSel <= d_ExtndSel;
      e_immF     <= d_immF;
      e_MemRead  <= d_MemRead;
      e_MemWrite <= d_MemWrite;
      e_RegWrite <= d_RegWrite;
      e_AluOp    <= d_AluOp;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [3:0]  d_R2, d_R3, d_DestR;
  logic [31:0] d_R2res, d_R3res;
  logic [1:0]  d_ExtndSel;
  logic        d_immF, d_MemRead, d_MemWrite, d_RegWrite;
  logic [3:0]  d_AluOp;
  logic        flush, mem_req, mem_ready;
  logic        e_valid;
  logic [3:0]  e_R2, e_R3, e_DestR;
  logic [31:0] e_R2res, e_R3res;
  logic [1:0]  e_ExtndSel;
  logic        e_immF, e_MemRead, e_MemWrite, e_RegWrite;
  logic [3:0]  e_AluOp;
  logic        stall_fd, stall_xm;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_R2(d_R2), .d_R3(d_R3),
    .d_DestR(d_DestR), .d_R2res(d_R2res), .d_R3res(d_R3res),
    .d_ExtndSel(d_ExtndSel), .d_immF(d_immF), .d_MemRead(d_MemRead),
    .d_MemWrite(d_MemWrite), .d_RegWrite(d_RegWrite), .d_AluOp(d_AluOp),
    .flush(flush), .mem_req(mem_req), .mem_ready(mem_ready),
    .e_valid(e_valid), .e_R2(e_R2), .e_R3(e_R3), .e_DestR(e_DestR),
    .e_R2res(e_R2res), .e_R3res(e_R3res), .e_ExtndSel(e_ExtndSel),
    .e_immF(e_immF), .e_MemRead(e_MemRead), .e_MemWrite(e_MemWrite),
    .e_RegWrite(e_RegWrite), .e_AluOp(e_AluOp),
    .stall_fd(stall_fd), .stall_xm(stall_xm), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] r2, input logic [3:0] r3,
                       input logic [3:0] dst, input logic [31:0] r2res,
                       input logic [31:0] r3res, input logic [1:0] ext,
                       input logic immf, input logic mr, input logic rw,
                       input logic [3:0] op);
    d_valid = v; d_R2 = r2; d_R3 = r3; d_DestR = dst;
    d_R2res = r2res; d_R3res = r3res; d_ExtndSel = ext; d_immF = immf;
    d_MemRead = mr; d_MemWrite = 1'b0; d_RegWrite = rw; d_AluOp = op;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    set_d(1, 4'd1, 4'd2, 4'd3, 32'h1111, 32'h2222, 2'b00, 0, 1, 1, 4'h1);

    // Reset held two cycles with a valid decode slot
    tick(); tick();
    chk("rst_e_valid", e_valid, 0);
    chk("rst_e_R2res", e_R2res, 0);
    chk("rst_e_DestR", e_DestR, 0);
    chk("rst_e_MemRead", e_MemRead, 0);
    chk("rst_stall_fd", stall_fd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    // Load to r5 enters execute
    rst = 1'b0;
    set_d(1, 4'd1, 4'd2, 4'd5, 32'h11, 32'h22, 2'b00, 0, 1, 1, 4'h1);
    tick();
    chk("ld_e_valid", e_valid, 1);
    chk("ld_e_MemRead", e_MemRead, 1);
    chk("ld_e_DestR", e_DestR, 5);

    // Consumer of r5 via R3: one bubble, then it advances
    set_d(1, 4'd3, 4'd5, 4'd7, 32'hAAAA, 32'hBBBB, 2'b00, 0, 0, 1, 4'h3);
    #1 chk("lu_stall_fd", stall_fd, 1);
    tick();
    chk("lu_bubble_valid", e_valid, 0);
    chk("lu_bubble_rw", e_RegWrite, 0);
    chk("lu_bubble_mr", e_MemRead, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_release_fd", stall_fd, 0);
    tick();
    chk("lu_adv_valid", e_valid, 1);
    chk("lu_adv_DestR", e_DestR, 7);
    chk("lu_adv_R3res", e_R3res, 32'hBBBB);
    chk("lu_adv_AluOp", e_AluOp, 3);
    chk("lu_adv_cnt", stall_cnt, 1);

    // Immediate masking against a load to r5
    set_d(1, 4'd1, 4'd2, 4'd5, 32'h11, 32'h22, 2'b00, 0, 1, 1, 4'h1);
    tick();
    set_d(1, 4'd0, 4'd5, 4'd8, 32'h0, 32'h0, 2'b10, 1, 0, 1, 4'h2);
    #1 chk("imm_r3_masked", stall_fd, 0);
    set_d(1, 4'd5, 4'd0, 4'd8, 32'h0, 32'h0, 2'b10, 1, 0, 1, 4'h2);
    #1 chk("imm_r2_masked", stall_fd, 0);
    set_d(1, 4'd0, 4'd5, 4'd8, 32'h0, 32'h0, 2'b00, 1, 0, 1, 4'h2);
    #1 chk("imm_r3_used_ext00", stall_fd, 1);
    set_d(1, 4'd5, 4'd0, 4'd8, 32'h0, 32'h0, 2'b01, 1, 0, 1, 4'h2);
    #1 chk("imm_r2_used_ext01", stall_fd, 1);
    set_d(0, 4'd5, 4'd5, 4'd8, 32'h0, 32'h0, 2'b00, 0, 0, 1, 4'h2);
    #1 chk("lu_invalid_decode", stall_fd, 0);

    // Memory wait of 3 cycles
    set_d(1, 4'd1, 4'd2, 4'd9, 32'hDEADBEEF, 32'h0, 2'b00, 0, 0, 1, 4'h4);
    tick();
    chk("mw_pre_R2res", e_R2res, 32'hDEADBEEF);
    set_d(1, 4'd1, 4'd2, 4'd10, 32'h1234, 32'h0, 2'b00, 0, 0, 1, 4'h5);
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 chk("mw_stall_xm", stall_xm, 1);
    chk("mw_stall_fd", stall_fd, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mw_hold_R2res", e_R2res, 32'hDEADBEEF);
      chk("mw_hold_DestR", e_DestR, 9);
    end
    chk("mw_cnt", stall_cnt, 4);
    mem_ready = 1'b1;
    #1 chk("mw_rel_xm", stall_xm, 0);
    tick();
    chk("mw_adv_R2res", e_R2res, 32'h1234);
    chk("mw_adv_cnt", stall_cnt, 4);

    // Deferred flush: pulse in 2nd cycle of a 4-cycle wait
    set_d(1, 4'd1, 4'd2, 4'd11, 32'h5555, 32'h0, 2'b00, 0, 0, 1, 4'h6);
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      tick();
      chk("df_hold_R2res", e_R2res, 32'h1234);
    end
    flush = 1'b0;
    chk("df_cnt", stall_cnt, 8);
    mem_ready = 1'b1;
    #1 chk("df_rel_fd", stall_fd, 0);
    tick();
    chk("df_bubble_valid", e_valid, 0);
    chk("df_bubble_R2res", e_R2res, 0);
    chk("df_bubble_rw", e_RegWrite, 0);
    tick();
    chk("df_after_valid", e_valid, 1);
    chk("df_after_R2res", e_R2res, 32'h5555);

    // Flush coinciding with a load-use hazard
    mem_req = 1'b0;
    set_d(1, 4'd1, 4'd2, 4'd5, 32'h11, 32'h22, 2'b00, 0, 1, 1, 4'h1);
    tick();
    set_d(1, 4'd3, 4'd5, 4'd7, 32'hAAAA, 32'hBBBB, 2'b00, 0, 0, 1, 4'h3);
    flush = 1'b1;
    #1 chk("fl_lu_fd", stall_fd, 0);
    tick();
    flush = 1'b0;
    chk("fl_lu_valid", e_valid, 0);
    chk("fl_lu_cnt", stall_cnt, 8);

    // Reset during a wait with a pending flush
    mem_req = 1'b1; mem_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b1;
    tick();
    chk("rmw_cnt", stall_cnt, 0);
    chk("rmw_valid", e_valid, 0);
    rst = 1'b0; mem_req = 1'b0;
    set_d(1, 4'd1, 4'd2, 4'd4, 32'h77, 32'h0, 2'b00, 0, 0, 1, 4'h7);
    tick();
    chk("rmw_adv_valid", e_valid, 1);
    chk("rmw_adv_R2res", e_R2res, 32'h77);

    // Saturation of the stall counter
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 70000 - 65535; i++) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_hold_R2res", e_R2res, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
